// File: rtl/sub32_serial.sv
// Serial two's-complement subtractor: diff = a - b, CHUNK bits per clock with a rippled borrow.
// Valid/ready on both sides; one operation in flight at a time.
module sub32_serial #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf
);

    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] KLAST = KW'(N - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    generate
        if (CHUNK <= 0 || (WIDTH % CHUNK) != 0) begin : g_chunk_check
            $error("sub32_serial: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    // One ripple slice: x + ~y + cin, carry-out in the top bit.
    function automatic logic [CHUNK:0] sub_slice(input logic [CHUNK-1:0] x,
                                                 input logic [CHUNK-1:0] y,
                                                 input logic             cin);
        return {1'b0, x} + {1'b0, ~y} + {{CHUNK{1'b0}}, cin};
    endfunction

    logic [1:0]       state;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry;
    logic [CHUNK:0]   slice;
    logic [CHUNK-1:0] s;
    logic             c_out;

    // Operands shift right one chunk per RUN cycle, so the active chunk is always the low one.
    assign slice = sub_slice(a_q[CHUNK-1:0], b_q[CHUNK-1:0], carry);
    assign s     = slice[CHUNK-1:0];
    assign c_out = slice[CHUNK];

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            k      <= '0;
            a_q    <= '0;
            b_q    <= '0;
            carry  <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b;
                        carry <= 1'b1;
                        k     <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_q   <= a_q >> CHUNK;
                    b_q   <= b_q >> CHUNK;
                    // Result chunks enter at the top; after N cycles chunk k sits at bits k*CHUNK.
                    diff  <= (diff >> CHUNK) | (WIDTH'(s) << (WIDTH - CHUNK));
                    carry <= c_out;
                    k     <= k + 1'b1;
                    if (k == KLAST) begin
                        // On the last chunk the low bits of a_q/b_q hold the operand MSBs.
                        borrow <= ~c_out;
                        ovf    <= (a_q[CHUNK-1] != b_q[CHUNK-1]) & (s[CHUNK-1] != a_q[CHUNK-1]);
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
